// File: rtl/rv32im_bus_pkg.sv
// Shared constants and types for the rv32im Wishbone bus arbiter.
package rv32im_bus_pkg;

  localparam int BUS_M_EXT       = 0;
  localparam int BUS_M_PREFETCH  = 1;
  localparam int BUS_M_MEM       = 2;

  localparam int BUS_NUM_MASTERS = 3;
  localparam int BUS_XLEN        = 32;
  localparam int ADR_W           = BUS_XLEN - 2;
  localparam int SEL_W           = 4;

  typedef enum logic {
    ARB_PARKED = 1'b0,
    ARB_BUSY   = 1'b1
  } arb_state_e;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv32im_bus_arb_pick.sv
// Combinational rotating-priority picker: first set request at or after i_ptr wins.
module rv32im_bus_arb_pick
  import rv32im_bus_pkg::*;
#(
  parameter int N     = BUS_NUM_MASTERS,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  logic w_found;

  // Walk candidates in priority order j = 0..N-1, mapped onto master (j + ptr) mod N.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int j = 0; j < N; j++) begin
      for (int m = 0; m < N; m++) begin
        if ((m == ((j + int'(i_ptr)) % N)) && i_req[m] && !w_found) begin
          o_grant[m] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rv32im_bus_arbiter.sv
// Wishbone-classic arbiter with registered one-hot grant parked on DEFAULT_MASTER.
// Define RV32IM_BUS_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index priority.
module rv32im_bus_arbiter
  import rv32im_bus_pkg::*;
#(
  parameter int XLEN           = BUS_XLEN,
  parameter int NUM_MASTERS    = BUS_NUM_MASTERS,
  parameter int DEFAULT_MASTER = BUS_M_PREFETCH
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [SEL_W*NUM_MASTERS-1:0]  m_sel_i,
  input  logic [(XLEN-2)*NUM_MASTERS-1:0] m_adr_i,
  input  logic [XLEN*NUM_MASTERS-1:0]   m_dat_i,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [XLEN-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic                          stb_o,
  output logic                          we_o,
  output logic [SEL_W-1:0]              sel_o,
  output logic [XLEN-3:0]               adr_o,
  output logic [XLEN-1:0]               dat_o,
  input  logic                          ack_i,
  input  logic                          err_i,
  input  logic [XLEN-1:0]               dat_i
);

  localparam int N     = NUM_MASTERS;
  localparam int AW    = XLEN - 2;
  localparam int PTR_W = ptr_width(N);
  localparam logic [N-1:0] DEF_GRANT = N'(1) << DEFAULT_MASTER;

  arb_state_e       r_state;
  arb_state_e       w_stateNext;
  logic [N-1:0]     r_grant;
  logic [N-1:0]     w_grantNext;
  logic [N-1:0]     w_pickGrant;
  logic [PTR_W-1:0] w_ptr;
  logic             w_ownerStb;
  logic             w_we;

  assign w_ownerStb = |(m_stb_i & r_grant);

  rv32im_bus_arb_pick #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_req   (m_stb_i),
    .i_ptr   (w_ptr),
    .o_grant (w_pickGrant)
  );

`ifdef RV32IM_BUS_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] r_rrPtr;
  logic [PTR_W-1:0] w_rrPtrNext;
  logic             w_arbIssue;

  // A fresh grant is issued whenever the owner is idle and someone requests.
  assign w_arbIssue = ~w_ownerStb & (|m_stb_i);

  always_comb begin
    w_rrPtrNext = r_rrPtr;
    for (int k = 0; k < N; k++) begin
      if (w_pickGrant[k]) w_rrPtrNext = PTR_W'((k + 1) % N);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)         r_rrPtr <= '0;
    else if (w_arbIssue) r_rrPtr <= w_rrPtrNext;
  end

  assign w_ptr = r_rrPtr;
`else
  assign w_ptr = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ARB_PARKED;
      r_grant <= DEF_GRANT;
    end else begin
      r_state <= w_stateNext;
      r_grant <= w_grantNext;
    end
  end

  // Grant is frozen while its owner strobes; otherwise re-arbitrate or fall back to parking.
  always_comb begin
    w_stateNext = r_state;
    w_grantNext = r_grant;
    case (r_state)
      ARB_PARKED: begin
        if (w_ownerStb) begin
          w_stateNext = ARB_BUSY;
        end else if (|m_stb_i) begin
          w_stateNext = ARB_BUSY;
          w_grantNext = w_pickGrant;
        end else begin
          w_grantNext = DEF_GRANT;
        end
      end
      ARB_BUSY: begin
        if (!w_ownerStb) begin
          if (|m_stb_i) begin
            w_grantNext = w_pickGrant;
          end else begin
            w_stateNext = ARB_PARKED;
            w_grantNext = DEF_GRANT;
          end
        end
      end
      default: begin
        w_stateNext = ARB_PARKED;
        w_grantNext = DEF_GRANT;
      end
    endcase
  end

  always_comb begin
    w_we  = 1'b0;
    sel_o = '0;
    adr_o = '0;
    dat_o = '0;
    for (int k = 0; k < N; k++) begin
      if (r_grant[k]) begin
        w_we  = m_we_i[k];
        sel_o = m_sel_i[k*SEL_W +: SEL_W];
        adr_o = m_adr_i[k*AW +: AW];
        dat_o = m_dat_i[k*XLEN +: XLEN];
      end
    end
  end

  assign grant_o = r_grant;
  assign stb_o   = w_ownerStb & ~reset_i;
  assign we_o    = w_we & stb_o;
  assign m_ack_o = {N{ack_i & ~reset_i}} & r_grant & m_stb_i;
  assign m_err_o = {N{err_i & ~reset_i}} & r_grant & m_stb_i;
  assign m_dat_o = dat_i;

endmodule

// File: doc/rv32im_bus_arbiter.md
Name: rv32im_bus_arbiter

Overview:
- Shares the single Wishbone-classic bus between NUM_MASTERS requesters: 0 = external/debug, 1 = prefetch, 2 = memory stage.
- Replaces the ad-hoc combinational prefetch/memory mux in the core.
- Registered one-hot grant with parking on a default master, so the parked master starts a transaction with zero added latency.
- A grant is held until the owning master drops stb; no preemption.

Parameters:
- XLEN, 32, data width; address width is XLEN-2 (word address).
- NUM_MASTERS, 3, number of requesters (2..8).
- DEFAULT_MASTER, 1, index parked on when idle and after reset.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- m_stb_i  in  NUM_MASTERS  per-master strobe/request
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_sel_i  in  4*NUM_MASTERS  per-master byte selects, master k at [4k+3:4k]
- m_adr_i  in  (XLEN-2)*NUM_MASTERS  per-master word address, packed like m_sel_i
- m_dat_i  in  XLEN*NUM_MASTERS  per-master write data
- m_ack_o  out  NUM_MASTERS  ack routed to the granted master only
- m_err_o  out  NUM_MASTERS  err routed to the granted master only
- m_dat_o  out  XLEN  read data, broadcast to all masters
- grant_o  out  NUM_MASTERS  registered one-hot grant
- stb_o  out  1  slave strobe
- we_o  out  1  slave write enable
- sel_o  out  4  slave byte selects
- adr_o  out  XLEN-2  slave word address
- dat_o  out  XLEN  slave write data
- ack_i  in  1  slave ack
- err_i  in  1  slave err
- dat_i  in  XLEN  slave read data

Behaviour:
- Reset: grant_o = one-hot(DEFAULT_MASTER). stb_o = 0. All m_ack_o/m_err_o = 0. Internal state = PARKED.
- Slave-side outputs (combinational):
  - stb_o = |(m_stb_i & grant_o).
  - we_o, sel_o, adr_o, dat_o = fields of the granted master.
  - When the granted master is not strobing, outputs still show its fields, but stb_o = 0 and we_o is forced to 0.
- Master-side responses: m_ack_o[k] = ack_i & grant_o[k] & m_stb_i[k]; same rule for m_err_o. m_dat_o = dat_i.
- State machine:
  - PARKED: grant on the default master, which is not strobing.
    - Default master asserts stb: goes BUSY with the same grant; stb_o rises the same cycle (zero latency).
    - Else, any other master requesting: next cycle grant moves to the highest-priority requester (lowest index); state BUSY.
  - BUSY: grant frozen while the granted master's stb is high, including across multiple acks (back-to-back hold).
    - Granted master's stb low: re-arbitrate in that cycle. Grant becomes the highest-priority active requester; if none, one-hot(DEFAULT_MASTER) and state PARKED.
- Grant switch latency: a non-parked requester sees its grant 1 cycle after the bus is free. Its stb_o propagates the cycle the grant is seen.
- The default master while parked is never blocked by the 1-cycle switch latency.
- Simultaneous events:
  - Owner drops stb while another master requests in the same cycle: the switch happens next cycle; no idle gap beyond that.
  - ack_i or err_i with no granted strobe: ignored, not routed.
  - err_i terminates like ack. The arbiter holds no error state.
- Reset mid-transaction: grant returns to the default master next edge and stb_o drops. The slave is responsible for abandoning the transaction.
- Invariant: grant_o is always exactly one-hot.

Optional Feature:
- Macro: RV32IM_BUS_ARB_ROUND_ROBIN_EN.
- Defined:
  - Re-arbitration uses rotating priority starting at (last owner + 1) mod NUM_MASTERS.
  - The rotation pointer updates only when a non-parked grant is issued; reset sets it to 0.
  - Parking behaviour is unchanged.
- Undefined: fixed priority, lowest index wins; no pointer register.

Decomposition:
- Shared package rv32im_bus_pkg:
  - Master index constants BUS_M_EXT = 0, BUS_M_PREFETCH = 1, BUS_M_MEM = 2.
  - Default NUM_MASTERS.
  - Width constants ADR_W = XLEN-2, SEL_W = 4.
- Sub-module rv32im_bus_arb_pick: combinational requester vector plus start pointer to one-hot winner. Fixed priority uses pointer 0.
- The top level holds the grant register, the PARKED/BUSY state and the field muxes.

Test Plan:
- Reset, then prefetch (m1) strobes at cycle 5 with adr 0x100; ack_i at cycle 6 -> stb_o = 1 at cycle 5, adr_o = 0x100, m_ack_o = 3'b010 at cycle 6, grant_o = 3'b010 throughout.
- m2 write (we = 1, sel = 4'b0011, dat 0xDEADBEEF) while parked on m1 -> grant_o = 3'b100 next cycle, we_o = 1, dat_o = 0xDEADBEEF; after ack and m2 drop, grant_o = 3'b010.
- m1 holds stb for 3 back-to-back acks while m0 requests -> m0 receives no grant until m1 drops; then grant_o = 3'b001 exactly 1 cycle later.
- m0 and m2 request simultaneously from idle -> fixed priority grants m0. With ROUND_ROBIN_EN and last owner m0, m2 is granted first.
- ack_i asserted with no strobe, and err_i during an m2 read -> m_ack_o stays 0 for the stray ack; m_err_o = 3'b100 only for the m2 read.
- reset_i asserted mid m2 transaction -> next edge grant_o = 3'b010, stb_o = 0; the one-hot check passes every cycle.
